alu_arbiter: RTL and testbench

- Shares one 16-bit alu instance between NREQ requesters, e.g. the instruction datapath and the address/branch unit.
- Round-robin grant with a per-requester valid/ready request channel and a single tagged response channel.
- Operands and op code are registered before the ALU; result and flags are registered after it.
- The alu is instantiated internally. Its select/opcode/arg1/arg2/result/carry/overflow pins are driven from internal registers only.

---
 rtl/alu_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 16-bit ALU between NREQ requesters
//
// alu_arbiter ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready [NREQ]  per-requester request handshake
//   req_op  [4*NREQ]            per-requester {select, opcode[2:0]}
//   req_a/req_b [16*NREQ]       per-requester ALU operands
//   rsp_valid/rsp_ready         single response handshake
//   rsp_id, rsp_result, rsp_carry, rsp_overflow   tagged response payload
//   busy                        high whenever the FSM is not idle
// Optional (macro ALU_ARBITER_GRANT_CNT_EN):
//   grant_cnt [16*NREQ]         per-requester accepted-transfer counters
//   clr_cnt                     synchronous clear of all counters
//
// alu ports: select, opcode[2:0], arg1, arg2 -> result, carry, overflow
//   select=0: add, sub, inc, dec, pass, neg, -, -
//   select=1: and, or, xor, not, shl1, shr1, shl by arg2[3:0], -
//   carry on subtract-style ops is the borrow; undefined codes give all zeros.

module alu (
    input  logic        select,
    input  logic [2:0]  opcode,
    input  logic [15:0] arg1,
    input  logic [15:0] arg2,
    output logic [15:0] result,
    output logic        carry,
    output logic        overflow
);
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic [16:0] sum;

    // All arithmetic codes are folded onto one add/subtract of (x, y).
    always_comb begin
        x   = arg1;
        y   = arg2;
        sub = 1'b0;
        case (opcode)
            3'd1: sub = 1'b1;
            3'd2: y = 16'd1;
            3'd3: begin y = 16'd1; sub = 1'b1; end
            3'd5: begin x = 16'd0; y = arg1; sub = 1'b1; end
            default: ;
        endcase
        sum = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    end

    always_comb begin
        result   = 16'd0;
        carry    = 1'b0;
        overflow = 1'b0;
        if (!select) begin
            case (opcode)
                3'd0, 3'd1, 3'd2, 3'd3, 3'd5: begin
                    result   = sum[15:0];
                    carry    = sum[16];
                    overflow = sub ? ((x[15] != y[15]) && (sum[15] != x[15]))
                                   : ((x[15] == y[15]) && (sum[15] != x[15]));
                end
                3'd4:    result = arg1;
                default: ;
            endcase
        end else begin
            case (opcode)
                3'd0: result = arg1 & arg2;
                3'd1: result = arg1 | arg2;
                3'd2: result = arg1 ^ arg2;
                3'd3: result = ~arg1;
                3'd4: begin result = {arg1[14:0], 1'b0}; carry = arg1[15]; end
                3'd5: begin result = {1'b0, arg1[15:1]}; carry = arg1[0]; end
                3'd6: result = arg1 << arg2[3:0];
                default: ;
            endcase
        end
    end
endmodule

module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_overflow,
    output logic                 busy
`ifdef ALU_ARBITER_GRANT_CNT_EN
    ,
    output logic [16*NREQ-1:0]   grant_cnt,
    input  logic                 clr_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic           xfer;

    logic [3:0]     sel_op;
    logic [15:0]    sel_a;
    logic [15:0]    sel_b;

    logic [3:0]     op_q;
    logic [15:0]    a_q;
    logic [15:0]    b_q;
    logic [IDW-1:0] id_q;

    logic [15:0]    alu_result;
    logic           alu_carry;
    logic           alu_overflow;

    // Round-robin search starting one past the last winner; the inner loop
    // keeps every index a loop constant so the selection stays a flat mux.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && req_valid[i] &&
                    ((int'(last_grant) + k == i) || (int'(last_grant) + k == i + NREQ))) begin
                    grant_any = 1'b1;
                    grant_idx = IDW'(i);
                end
            end
        end
    end

    assign xfer = (state == IDLE) && grant_any;

    always_comb begin
        sel_op = 4'd0;
        sel_a  = 16'd0;
        sel_b  = 16'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[16*i +: 16];
                sel_b  = req_b[16*i +: 16];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. req_ready is forced low while reset is held.
    always_comb begin
        busy      = (state != IDLE);
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer && rst_n && (grant_idx == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Operand capture and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 4'd0;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            id_q       <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (xfer) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= grant_idx;
            last_grant <= grant_idx;
        end
    end

    alu u_alu (
        .select   (op_q[3]),
        .opcode   (op_q[2:0]),
        .arg1     (a_q),
        .arg2     (b_q),
        .result   (alu_result),
        .carry    (alu_carry),
        .overflow (alu_overflow)
    );

    // Response registers only load in EXEC, so they keep the last payload
    // after the handshake until the next operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= 16'd0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= id_q;
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end

`ifdef ALU_ARBITER_GRANT_CNT_EN
    logic [15:0] cnt_q [NREQ];

    // A clear that coincides with a grant leaves the winner at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (xfer && (grant_idx == IDW'(i))) begin
                    cnt_q[i] <= clr_cnt ? 16'd1 : cnt_q[i] + 16'd1;
                end else if (clr_cnt) begin
                    cnt_q[i] <= 16'd0;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[16*i +: 16] = cnt_q[i];
        end
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard testbench for alu_arbiter
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_op;
    logic [16*NREQ-1:0]  req_a;
    logic [16*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_result;
    logic                rsp_carry;
    logic                rsp_overflow;
    logic                busy;
`ifdef ALU_ARBITER_GRANT_CNT_EN
    logic [16*NREQ-1:0]  grant_cnt;
    logic                clr_cnt;
`endif

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
`ifdef ALU_ARBITER_GRANT_CNT_EN
        ,
        .grant_cnt    (grant_cnt),
        .clr_cnt      (clr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference ALU computed from integer arithmetic: returns {result, carry, overflow}.
    function automatic logic [17:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, r, c, v;
        logic [15:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = 0; c = 0; v = 0;
        case (op)
            4'd0:  begin r = ua + ub; c = int'(r > 65535); v = int'((sa + sb > 32767) || (sa + sb < -32768)); end
            4'd1:  begin r = ua - ub; c = int'(ua < ub);   v = int'((sa - sb > 32767) || (sa - sb < -32768)); end
            4'd2:  begin r = ua + 1;  c = int'(r > 65535); v = int'(sa + 1 > 32767); end
            4'd3:  begin r = ua - 1;  c = int'(ua < 1);    v = int'(sa - 1 < -32768); end
            4'd4:  r = ua;
            4'd5:  begin r = 0 - ua;  c = int'(ua > 0);    v = int'(0 - sa > 32767); end
            4'd8:  r = ua & ub;
            4'd9:  r = ua | ub;
            4'd10: r = ua ^ ub;
            4'd11: r = 65535 - ua;
            4'd12: begin r = ua * 2;  c = int'(ua >= 32768); end
            4'd13: begin r = ua / 2;  c = ua % 2; end
            4'd14: r = ua * (1 << (ub % 16));
            default: r = 0;
        endcase
        res = r[15:0];
        return {res, c[0], v[0]};
    endfunction

    // Scoreboard and model state
    logic [19:0] sb[$];
    int          grants[$];
    int          m_phase;        // 0 idle, 1 computing, 2 holding response
    int          m_last_grant;
    logic [19:0] m_last_rsp;
    int          m_cnt [NREQ];

    initial begin
        m_phase      = 0;
        m_last_grant = NREQ - 1;
        m_last_rsp   = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end

    // Monitor: sample away from the rising edge, compare, then advance the model.
    always @(negedge clk) begin
        int          winner;
        logic [NREQ-1:0] exp_ready;
        logic [19:0] payload;
        payload = {rsp_id, rsp_result, rsp_carry, rsp_overflow};
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_payload", payload, 0);
            m_phase      = 0;
            m_last_grant = NREQ - 1;
            m_last_rsp   = '0;
            sb.delete();
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
`ifdef ALU_ARBITER_GRANT_CNT_EN
            chk("rst_grant_cnt", grant_cnt, 0);
`endif
        end else begin
            winner    = -1;
            exp_ready = '0;
            if (m_phase == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int cand;
                    cand = (m_last_grant + k) % NREQ;
                    if (winner < 0 && req_valid[cand]) winner = cand;
                end
                if (winner >= 0) exp_ready[winner] = 1'b1;
            end
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, m_phase != 0);
            chk("rsp_valid", rsp_valid, m_phase == 2);
            if (m_phase == 2) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else chk("rsp_payload", payload, sb[0]);
            end else begin
                chk("rsp_hold", payload, m_last_rsp);
            end
`ifdef ALU_ARBITER_GRANT_CNT_EN
            begin
                logic [16*NREQ-1:0] exp_cnt;
                for (int i = 0; i < NREQ; i++) exp_cnt[16*i +: 16] = m_cnt[i][15:0];
                chk("grant_cnt", grant_cnt, exp_cnt);
            end
`endif
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) grants.push_back(i);
            end
            // Advance the model to the state after the coming rising edge.
            case (m_phase)
                0: if (winner >= 0) begin
                    sb.push_back({IDW'(winner),
                                  ref_alu(req_op[4*winner +: 4], req_a[16*winner +: 16], req_b[16*winner +: 16])});
                    m_last_grant = winner;
                    m_phase      = 1;
                end
                1: m_phase = 2;
                default: if (rsp_ready) begin
                    if (sb.size() > 0) m_last_rsp = sb.pop_front();
                    m_phase = 0;
                end
            endcase
`ifdef ALU_ARBITER_GRANT_CNT_EN
            if (clr_cnt) for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
            if (winner >= 0) m_cnt[winner] = (m_cnt[winner] + 1) % 65536;
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            cyc(1);
            n++;
        end
        if (!rsp_valid) begin
            total++;
            $display("FAIL rsp_timeout: rsp_valid never rose at %0t", $time);
        end
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef ALU_ARBITER_GRANT_CNT_EN
        clr_cnt   = 1'b0;
`endif
        cyc(3);

        // Fairness: both requesters valid from the first cycle after reset.
        rst_n = 1'b1;
        grants.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_op[4*i +: 4]  = 4'(i);
            req_a[16*i +: 16] = 16'(100 + i);
            req_b[16*i +: 16] = 16'd7;
        end
        cyc(18);
        req_valid = '0;
        chk("rr_count", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++) chk("rr_order", grants[i], i % 2);

`ifdef ALU_ARBITER_GRANT_CNT_EN
        req_valid = 2'b01;
        cyc(6);
        req_valid = '0;
        chk("cnt_5_3", grant_cnt, {16'd3, 16'd5});
        req_valid = 2'b01;
        clr_cnt   = 1'b1;
        cyc(1);
        clr_cnt   = 1'b0;
        req_valid = '0;
        chk("cnt_clr_with_grant", grant_cnt, {16'd0, 16'd1});
        cyc(3);
`endif

        // Single request from requester 1
        req_op[7:4]   = 4'b0000;
        req_a[31:16]  = 16'd15;
        req_b[31:16]  = 16'd2;
        req_valid     = 2'b10;
        cyc(1);
        req_valid     = '0;
        cyc(4);
        chk("single_result", {rsp_id, rsp_result, rsp_carry, rsp_overflow}, {2'd1, 16'd17, 1'b0, 1'b0});

        // Backpressure with requester 0 still valid
        rsp_ready    = 1'b0;
        req_op[3:0]  = 4'd1;
        req_a[15:0]  = 16'd3;
        req_b[15:0]  = 16'd5;
        req_valid    = 2'b01;
        wait_rsp();
        cyc(10);
        rsp_ready    = 1'b1;
        cyc(2);
        req_valid    = '0;
        cyc(4);

        // Reset while a response is held
        rsp_ready    = 1'b0;
        req_op[3:0]  = 4'd0;
        req_a[15:0]  = 16'h8000;
        req_b[15:0]  = 16'd2;
        req_valid    = 2'b01;
        wait_rsp();
        req_valid    = '0;
        rst_n        = 1'b0;
        #1;
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_busy", busy, 0);
        cyc(2);
        rst_n        = 1'b1;
        rsp_ready    = 1'b1;
        cyc(5);

        // Randomized traffic
        repeat (400) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_op[4*i +: 4]  = 4'($urandom);
                req_a[16*i +: 16] = pick_operand();
                req_b[16*i +: 16] = pick_operand();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_ARBITER_GRANT_CNT_EN
            clr_cnt   = ($urandom_range(0, 15) == 0);
`endif
            cyc(1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
`ifdef ALU_ARBITER_GRANT_CNT_EN
        clr_cnt   = 1'b0;
`endif
        cyc(5);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
